load_store_unit: RTL and testbench

- Sits between the core execute stage and the data memory.
- Converts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned accesses on the data memory port.
- The memory port has only a combinational word read and a synchronous full-word write.
- Sub-word stores are therefore done as read-modify-write. Loads are lane-extracted and sign/zero-extended. Misaligned or illegal requests are reported to the core.

---
 rtl/load_store_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: turns RV32I load/store requests into word-aligned
// accesses on a memory port with combinational read and synchronous write.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
`ifndef XLEN
`define XLEN 32
`endif

module load_store_unit #(
  parameter bit FAULT_ON_MISALIGN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [`XLEN-1:0]  i_addr,
  input  logic [`XLEN-1:0]  i_wdata,
  output logic              o_busy,
  output logic              o_ack,
  output logic [`XLEN-1:0]  o_rdata,
  output logic              o_fault,
  output logic [`XLEN-1:0]  o_mem_addr,
  output logic [`XLEN-1:0]  o_mem_wd,
  output logic              o_mem_wen,
  input  logic [`XLEN-1:0]  i_mem_rd
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_RMW_RD = 3'd2,
    S_RMW_WR = 3'd3,
    S_RESP   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3 legality differs between loads and stores (no unsigned stores)
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

  // size is carried in funct3[1:0]: 01 half, 10 word
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = lo[0];
      2'b10:   mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // force natural alignment by clearing the low address bits for the size
  function automatic logic [`XLEN-1:0] align_addr(input logic [2:0] f3,
                                                  input logic [`XLEN-1:0] a);
    logic [`XLEN-1:0] r;
    case (f3[1:0])
      2'b01:   r = {a[`XLEN-1:1], 1'b0};
      2'b10:   r = {a[`XLEN-1:2], 2'b00};
      default: r = a;
    endcase
    return r;
  endfunction

  // pick the addressed lane out of a memory word and sign/zero-extend it
  function automatic logic [`XLEN-1:0] extract_load(input logic [2:0] f3,
                                                    input logic [1:0] lane,
                                                    input logic [`XLEN-1:0] word);
    logic [7:0]       b;
    logic [15:0]      h;
    logic [`XLEN-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_W:    r = word;
      F3_BU:   r = {24'h00_0000, b};
      F3_HU:   r = {16'h0000, h};
      default: r = {`XLEN{1'b0}};
    endcase
    return r;
  endfunction

  // overlay store data onto the old memory word in the addressed lane
  function automatic logic [`XLEN-1:0] merge_store(input logic [2:0] f3,
                                                   input logic [1:0] lane,
                                                   input logic [`XLEN-1:0] word,
                                                   input logic [`XLEN-1:0] wd);
    logic [`XLEN-1:0] r;
    r = word;
    case (f3)
      F3_B:    r[{lane, 3'b000} +: 8]     = wd[7:0];
      F3_H:    r[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  state_t            r_state;
  state_t            w_next_state;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [`XLEN-1:0]  r_addr;
  logic [`XLEN-1:0]  r_wd;
  logic [`XLEN-1:0]  r_rdata;

  logic              w_illegal;
  logic              w_misaligned;
  logic              w_fault;
  logic              w_subword_store;
  logic [`XLEN-1:0]  w_eff_addr;

  // classify the incoming request; only consumed in IDLE
  always_comb begin
    w_illegal       = ~funct3_legal(i_we, i_funct3);
    w_misaligned    = is_misaligned(i_funct3, i_addr[1:0]);
    w_fault         = w_illegal | (FAULT_ON_MISALIGN & w_misaligned);
    w_subword_store = i_we & (i_funct3 != F3_W);
    if (FAULT_ON_MISALIGN) begin
      w_eff_addr = i_addr;
    end else begin
      w_eff_addr = align_addr(i_funct3, i_addr);
    end
  end

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // next-state decode; a forced-aligned SH still needs read-modify-write
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          if (w_fault) begin
            w_next_state = S_FAULT;
          end else if (w_subword_store) begin
            w_next_state = S_RMW_RD;
          end else begin
            w_next_state = S_ACCESS;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ACCESS: w_next_state = S_RESP;
      S_RMW_RD: w_next_state = S_RMW_WR;
      S_RMW_WR: w_next_state = S_RESP;
      S_RESP:   w_next_state = S_IDLE;
      S_FAULT:  w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // request latch, load capture and store merge; r_wd holds wdata then the merged word
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= {`XLEN{1'b0}};
      r_wd     <= {`XLEN{1'b0}};
      r_rdata  <= {`XLEN{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_we     <= i_we;
            r_funct3 <= i_funct3;
            r_addr   <= w_eff_addr;
            r_wd     <= i_wdata;
            r_rdata  <= {`XLEN{1'b0}};
          end
        end
        S_ACCESS: begin
          if (!r_we) begin
            r_rdata <= extract_load(r_funct3, r_addr[1:0], i_mem_rd);
          end
        end
        S_RMW_RD: begin
          r_wd <= merge_store(r_funct3, r_addr[1:0], i_mem_rd, r_wd);
        end
        default: begin
          r_wd <= r_wd;
        end
      endcase
    end
  end

  // outputs decoded from registered state and latched data only
  always_comb begin
    o_busy     = (r_state != S_IDLE);
    o_ack      = (r_state == S_RESP) || (r_state == S_FAULT);
    o_fault    = (r_state == S_FAULT);
    o_mem_wen  = ((r_state == S_ACCESS) && r_we) || (r_state == S_RMW_WR);
    o_mem_addr = {r_addr[`XLEN-1:2], 2'b00};
    o_mem_wd   = r_wd;
    if (r_state == S_RESP) begin
      o_rdata = r_rdata;
    end else begin
      o_rdata = {`XLEN{1'b0}};
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: two instances (misalign faults on
// and off), each with its own word memory and a byte-level reference model.
`timescale 1ns/1ps

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req [2];
  logic        we;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy [2];
  logic        ack [2];
  logic        fault [2];
  logic        mwen [2];
  logic [31:0] rdata [2];
  logic [31:0] maddr [2];
  logic [31:0] mwd [2];
  logic [31:0] mrd [2];

  logic [31:0] mem [2][256];
  logic        pl_en;
  int          pl_sel;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  logic [7:0]  rmem [2][1024];
  int          checks;
  int          failures;

  always #5 clk = ~clk;

  load_store_unit #(.FAULT_ON_MISALIGN(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req[0]), .i_we(we), .i_funct3(f3),
    .i_addr(addr), .i_wdata(wdata), .o_busy(busy[0]), .o_ack(ack[0]),
    .o_rdata(rdata[0]), .o_fault(fault[0]), .o_mem_addr(maddr[0]),
    .o_mem_wd(mwd[0]), .o_mem_wen(mwen[0]), .i_mem_rd(mrd[0])
  );

  load_store_unit #(.FAULT_ON_MISALIGN(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req[1]), .i_we(we), .i_funct3(f3),
    .i_addr(addr), .i_wdata(wdata), .o_busy(busy[1]), .o_ack(ack[1]),
    .o_rdata(rdata[1]), .o_fault(fault[1]), .o_mem_addr(maddr[1]),
    .o_mem_wd(mwd[1]), .o_mem_wen(mwen[1]), .i_mem_rd(mrd[1])
  );

  assign mrd[0] = mem[0][maddr[0][9:2]];
  assign mrd[1] = mem[1][maddr[1][9:2]];

  // behavioural memories: preload port plus the DUT write ports
  always @(posedge clk) begin
    if (pl_en) mem[pl_sel][pl_idx] <= pl_data;
    if (mwen[0]) mem[0][maddr[0][9:2]] <= mwd[0];
    if (mwen[1]) mem[1][maddr[1][9:2]] <= mwd[1];
  end

  // absolute time bound for the whole run
  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit fom(int sel);
    return (sel == 1);
  endfunction

  function automatic logic [31:0] ref_word(int sel, int w);
    return {rmem[sel][4*w+3], rmem[sel][4*w+2], rmem[sel][4*w+1], rmem[sel][4*w]};
  endfunction

  task automatic preload(input int sel, input int idx, input logic [31:0] data);
    pl_sel  = sel;
    pl_idx  = idx[7:0];
    pl_data = data;
    pl_en   = 1'b1;
    @(posedge clk); #1;
    pl_en   = 1'b0;
    for (int k = 0; k < 4; k++) rmem[sel][4*idx+k] = data[8*k +: 8];
  endtask

  // one request, held until ack, checked against the byte-level model
  task automatic do_op(input int sel, input logic w, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] wd,
                       input string name, output logic [31:0] got_rd);
    bit          legal;
    bit          mis;
    bit          exp_fault;
    int          nb;
    int          ba;
    int          exp_lat;
    int          exp_wen;
    int          cyc;
    int          wen_cnt;
    bit          leak;
    logic [31:0] exp_rd;

    legal = w ? (fn <= 3'd2) : (fn inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nb    = (fn[1:0] == 2'b00) ? 1 : (fn[1:0] == 2'b01) ? 2 : 4;
    ba    = int'(a[9:0]);
    mis   = (ba % nb) != 0;
    exp_fault = !legal || (fom(sel) && mis);
    if (!exp_fault) ba = ba - (ba % nb);
    exp_lat = exp_fault ? 1 : ((w && nb < 4) ? 3 : 2);
    exp_wen = (!exp_fault && w) ? 1 : 0;
    exp_rd  = 32'h0;
    if (!w && !exp_fault) begin
      for (int k = 0; k < nb; k++) exp_rd[8*k +: 8] = rmem[sel][ba+k];
      if (!fn[2] && nb < 4 && exp_rd[8*nb-1]) begin
        for (int k = nb; k < 4; k++) exp_rd[8*k +: 8] = 8'hFF;
      end
    end

    req[sel] = 1'b1; we = w; f3 = fn; addr = a; wdata = wd;
    @(posedge clk); #1;
    cyc = 1; wen_cnt = 0; leak = 1'b0;
    while (!ack[sel] && cyc < 8) begin
      if (mwen[sel]) wen_cnt++;
      if (rdata[sel] !== 32'h0 || fault[sel] !== 1'b0) leak = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    req[sel] = 1'b0;
    got_rd = rdata[sel];

    checks++;
    if (cyc !== exp_lat) begin
      failures++;
      $display("FAIL %s latency sel=%0d got=%0d exp=%0d", name, sel, cyc, exp_lat);
    end
    checks++;
    if (fault[sel] !== exp_fault) begin
      failures++;
      $display("FAIL %s fault sel=%0d got=%b exp=%b", name, sel, fault[sel], exp_fault);
    end
    checks++;
    if (rdata[sel] !== exp_rd) begin
      failures++;
      $display("FAIL %s rdata sel=%0d got=%h exp=%h", name, sel, rdata[sel], exp_rd);
    end
    checks++;
    if (wen_cnt !== exp_wen) begin
      failures++;
      $display("FAIL %s wen_cycles sel=%0d got=%0d exp=%0d", name, sel, wen_cnt, exp_wen);
    end
    checks++;
    if (leak) begin
      failures++;
      $display("FAIL %s rdata_fault_without_ack sel=%0d got=1 exp=0", name, sel);
    end

    if (w && !exp_fault) begin
      for (int k = 0; k < nb; k++) rmem[sel][ba+k] = wd[8*k +: 8];
    end
    @(posedge clk); #1;
    checks++;
    if (mem[sel][ba/4] !== ref_word(sel, ba/4)) begin
      failures++;
      $display("FAIL %s memword sel=%0d got=%h exp=%h", name, sel, mem[sel][ba/4], ref_word(sel, ba/4));
    end
    checks++;
    if (busy[sel] !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after sel=%0d got=%b exp=0", name, sel, busy[sel]);
    end
  endtask

  task automatic chk_outputs_zero(input int sel, input string name);
    checks++;
    if (busy[sel] !== 1'b0 || ack[sel] !== 1'b0 || fault[sel] !== 1'b0 ||
        rdata[sel] !== 32'h0 || mwen[sel] !== 1'b0 || maddr[sel] !== 32'h0 ||
        mwd[sel] !== 32'h0) begin
      failures++;
      $display("FAIL %s sel=%0d got busy=%b ack=%b fault=%b rdata=%h wen=%b maddr=%h wd=%h exp all zero",
               name, sel, busy[sel], ack[sel], fault[sel], rdata[sel], mwen[sel], maddr[sel], mwd[sel]);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst_n = 1'b0; req[0] = 1'b1; req[1] = 1'b1;
    we = 1'b0; f3 = 3'b010; addr = 32'h0; wdata = 32'h0; pl_en = 1'b0;
    pl_sel = 0; pl_idx = 8'h0; pl_data = 32'h0;
    #3;
    chk_outputs_zero(0, "reset_early");
    chk_outputs_zero(1, "reset_early");
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) preload(s, i, $urandom);
    end
    chk_outputs_zero(0, "reset_held");
    chk_outputs_zero(1, "reset_held");
    req[0] = 1'b0;
    rst_n = 1'b1;
    do_op(1, 1'b0, 3'b010, 32'h0, 32'h0, "reset_first_req", r);
  endtask

  task automatic test_loads();
    logic [31:0] r;
    preload(1, 32'h100 >> 2, 32'h8001_7FFF);
    do_op(1, 1'b0, 3'b000, 32'h103, 32'h0, "lb_103", r);
    checks++; if (r !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_const got=%h exp=ffffff80", r); end
    do_op(1, 1'b0, 3'b100, 32'h103, 32'h0, "lbu_103", r);
    checks++; if (r !== 32'h0000_0080) begin failures++; $display("FAIL lbu_const got=%h exp=00000080", r); end
    do_op(1, 1'b0, 3'b001, 32'h100, 32'h0, "lh_100", r);
    checks++; if (r !== 32'h0000_7FFF) begin failures++; $display("FAIL lh_const got=%h exp=00007fff", r); end
    do_op(1, 1'b0, 3'b101, 32'h102, 32'h0, "lhu_102", r);
    do_op(1, 1'b0, 3'b010, 32'h100, 32'h0, "lw_100", r);
    checks++; if (r !== 32'h8001_7FFF) begin failures++; $display("FAIL lw_const got=%h exp=80017fff", r); end
  endtask

  task automatic test_stores();
    logic [31:0] r;
    preload(1, 32'h200 >> 2, 32'h1122_3344);
    do_op(1, 1'b1, 3'b000, 32'h201, 32'h0000_00AB, "sb_201", r);
    checks++; if (mem[1][8'h80] !== 32'h1122_AB44) begin failures++; $display("FAIL sb_const got=%h exp=1122ab44", mem[1][8'h80]); end
    do_op(1, 1'b1, 3'b001, 32'h202, 32'h0000_BEEF, "sh_202", r);
    checks++; if (mem[1][8'h80] !== 32'hBEEF_AB44) begin failures++; $display("FAIL sh_const got=%h exp=beefab44", mem[1][8'h80]); end
    do_op(1, 1'b1, 3'b010, 32'h204, 32'hCAFE_F00D, "sw_204", r);
  endtask

  task automatic test_misalign();
    logic [31:0] r;
    do_op(1, 1'b0, 3'b010, 32'h102, 32'h0, "mis_lw_fault", r);
    do_op(1, 1'b1, 3'b001, 32'h203, 32'h0000_1234, "mis_sh_fault", r);
    preload(0, 32'h100 >> 2, 32'h8001_7FFF);
    do_op(0, 1'b0, 3'b010, 32'h102, 32'h0, "mis_lw_aligned", r);
    checks++; if (r !== 32'h8001_7FFF) begin failures++; $display("FAIL mis_lw_aligned_const got=%h exp=80017fff", r); end
    do_op(0, 1'b1, 3'b001, 32'h203, 32'h0000_5678, "mis_sh_aligned", r);
    do_op(0, 1'b0, 3'b101, 32'h101, 32'h0, "mis_lhu_aligned", r);
  endtask

  task automatic test_illegal();
    logic [31:0] r;
    for (int s = 0; s < 2; s++) begin
      do_op(s, 1'b0, 3'b011, 32'h100, 32'h0, "illegal_load_011", r);
      do_op(s, 1'b1, 3'b100, 32'h200, 32'hFFFF_FFFF, "illegal_store_100", r);
      do_op(s, 1'b1, 3'b110, 32'h204, 32'h1234_5678, "illegal_store_110", r);
    end
  endtask

  task automatic test_busy_ignore();
    int acks;
    req[1] = 1'b1; we = 1'b1; f3 = 3'b000; addr = 32'h240; wdata = 32'h0000_005A;
    @(posedge clk); #1;
    req[1] = 1'b0;
    acks = 0;
    for (int c = 1; c < 8; c++) begin
      if (ack[1]) acks++;
      if (c == 1) begin
        req[1] = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h244; wdata = 32'hDEAD_BEEF;
      end
      if (c == 3) req[1] = 1'b0;
      @(posedge clk); #1;
    end
    rmem[1][32'h240] = 8'h5A;
    checks++;
    if (acks !== 1) begin failures++; $display("FAIL busy_ignore acks got=%0d exp=1", acks); end
    checks++;
    if (mem[1][8'h90] !== ref_word(1, 32'h90)) begin
      failures++; $display("FAIL busy_ignore sb_word got=%h exp=%h", mem[1][8'h90], ref_word(1, 32'h90));
    end
    checks++;
    if (mem[1][8'h91] !== ref_word(1, 32'h91)) begin
      failures++; $display("FAIL busy_ignore ignored_word got=%h exp=%h", mem[1][8'h91], ref_word(1, 32'h91));
    end
  endtask

  task automatic test_reset_mid_rmw();
    logic [31:0] r;
    int n;
    int acks;
    req[1] = 1'b1; we = 1'b1; f3 = 3'b000; addr = 32'h281; wdata = 32'h0000_0077;
    @(posedge clk); #1;
    req[1] = 1'b0;
    n = 0;
    while (!mwen[1] && n < 5) begin @(posedge clk); #1; n++; end
    checks++;
    if (mwen[1] !== 1'b1) begin failures++; $display("FAIL midrst reach_rmw_wr got=%b exp=1", mwen[1]); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mwen[1] !== 1'b0 || busy[1] !== 1'b0 || ack[1] !== 1'b0) begin
      failures++;
      $display("FAIL midrst outputs got wen=%b busy=%b ack=%b exp 0 0 0", mwen[1], busy[1], ack[1]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      if (ack[1]) acks++;
      @(posedge clk); #1;
    end
    checks++;
    if (acks !== 0) begin failures++; $display("FAIL midrst no_ack got=%0d exp=0", acks); end
    checks++;
    if (mem[1][8'hA0] !== ref_word(1, 32'hA0)) begin
      failures++; $display("FAIL midrst mem_unchanged got=%h exp=%h", mem[1][8'hA0], ref_word(1, 32'hA0));
    end
    do_op(1, 1'b0, 3'b010, 32'h280, 32'h0, "midrst_after_lw", r);
  endtask

  task automatic test_random();
    logic [31:0] r;
    int sel;
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 1);
      do_op(sel, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'h300 + 32'($urandom_range(0, 255)), $urandom, "random", r);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_loads();
    test_stores();
    test_misalign();
    test_illegal();
    test_busy_ignore();
    test_reset_mid_rmw();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
